// File: rtl/psum_accum.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum
// Purpose  : Multi-pass partial-sum accumulator for the bottom edge of a
//            systolic array. Each pass streams depth rows of col signed
//            lanes into a bank, which is overwritten on pass 0 and
//            saturating-accumulated on later passes. After the last pass
//            the bank is drained row by row under a valid/ready handshake.
// Config   : define PSUM_ACCUM_RELU_EN to clamp negative lanes to zero on
//            the drain path. Bank contents stay raw in either build.
// Revision : 1.0 - initial release
// ============================================================================
module psum_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int aw      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               num_pass,
  input  logic [col*psum_bw-1:0]   in_psum,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [aw-1:0] LAST_ADDR = aw'(depth - 1);

  state_t                   state_q;
  logic [aw-1:0]            wr_addr_q;
  logic [aw-1:0]            rd_addr_q;
  logic [3:0]               pass_cnt_q;
  logic [3:0]               num_pass_q;
  logic                     done_q;

  // One packed row per output pixel; never reset because pass 0 overwrites.
  logic [col*psum_bw-1:0]   bank_q [depth];

  logic [col*psum_bw-1:0]   wr_row_d;
  logic [col*psum_bw-1:0]   rd_row;
  logic                     beat_acc;
  logic                     drain_hs;
  logic                     last_pass;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  assign beat_acc  = in_valid & in_ready;
  assign drain_hs  = out_valid & out_ready;
  assign last_pass = (pass_cnt_q == 4'(num_pass_q - 4'd1));
  assign rd_row    = bank_q[rd_addr_q];

  // Per-lane write data (overwrite or saturating add) and drain transform.
  for (genvar k = 0; k < col; k++) begin : g_lane
    localparam logic signed [psum_bw-1:0] SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    logic signed [psum_bw-1:0] old_v;
    logic signed [psum_bw-1:0] new_v;
    logic signed [psum_bw:0]   sum_v;
    logic signed [psum_bw-1:0] acc_v;
    logic signed [psum_bw-1:0] rd_v;
    logic signed [psum_bw-1:0] drain_v;

    assign old_v = bank_q[wr_addr_q][k*psum_bw +: psum_bw];
    assign new_v = in_psum[k*psum_bw +: psum_bw];
    // One guard bit is enough to detect overflow of a two-operand add.
    assign sum_v = {old_v[psum_bw-1], old_v} + {new_v[psum_bw-1], new_v};

    // Select overwrite on the first pass, otherwise clamp the widened sum.
    always_comb begin
      acc_v = sum_v[psum_bw-1:0];
      if (pass_cnt_q == 4'd0) begin
        acc_v = new_v;
      end else if (sum_v[psum_bw] != sum_v[psum_bw-1]) begin
        acc_v = sum_v[psum_bw] ? SAT_MIN : SAT_MAX;
      end
    end

    assign wr_row_d[k*psum_bw +: psum_bw] = acc_v;

    assign rd_v = rd_row[k*psum_bw +: psum_bw];
`ifdef PSUM_ACCUM_RELU_EN
    assign drain_v = rd_v[psum_bw-1] ? '0 : rd_v;
`else
    assign drain_v = rd_v;
`endif

    // Output is forced to zero outside DRAIN so idle/reset shows no data.
    assign out_data[k*psum_bw +: psum_bw] = (state_q == DRAIN) ? drain_v : '0;
  end

  // Bank write port: one row per accepted input beat.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      bank_q[wr_addr_q] <= wr_row_d;
    end
  end

  // Control FSM: job launch, pass/address counting, drain sequencing, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      pass_cnt_q <= '0;
      num_pass_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_pass_q <= (num_pass == 4'd0) ? 4'd1 : num_pass;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            pass_cnt_q <= '0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat_acc) begin
            if (wr_addr_q == LAST_ADDR) begin
              wr_addr_q <= '0;
              if (last_pass) begin
                state_q <= DRAIN;
              end else begin
                pass_cnt_q <= pass_cnt_q + 4'd1;
              end
            end else begin
              wr_addr_q <= wr_addr_q + aw'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_hs) begin
            if (rd_addr_q == LAST_ADDR) begin
              rd_addr_q <= '0;
              state_q   <= IDLE;
              done_q    <= 1'b1;
            end else begin
              rd_addr_q <= rd_addr_q + aw'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameters SHALL be: col, default 8, number of array columns (lanes); psum_bw, default 16, signed psum width per lane; depth, default 16, output pixels per pass; aw, default 4, address width, with depth <= 2^aw.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle job request; honoured only in IDLE.
REQ-005 num_pass  input  4  passes to accumulate per job, sampled on an accepted start; 0 is treated as 1.
REQ-006 in_psum  input  col*psum_bw  one row of signed psums from the array bottom; lane k occupies bits [k*psum_bw +: psum_bw].
REQ-007 in_valid  input  1  in_psum is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_psum this cycle.
REQ-009 out_data  output  col*psum_bw  drained result row, same lane packing as in_psum.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 busy  output  1  high in ACCUM and DRAIN.
REQ-013 done  output  1  one-cycle pulse at the end of a job.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, ACCUM and DRAIN.
REQ-015 IDLE: start=1 SHALL latch num_pass, clear wr_addr, rd_addr and pass_cnt, and move to ACCUM the next cycle.
REQ-016 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid & in_ready.
REQ-017 An accepted beat on pass 0 SHALL write bank[wr_addr] = in_psum per lane, overwriting; no explicit clear is needed.
REQ-018 An accepted beat on later passes SHALL write bank[wr_addr] = bank[wr_addr] + in_psum per lane, signed, saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-019 wr_addr SHALL increment per accepted beat; at depth-1 it wraps to 0 and pass_cnt increments.
REQ-020 The accepted beat at wr_addr=depth-1 on pass num_pass-1 SHALL move the FSM to DRAIN the next cycle.
REQ-021 DRAIN SHALL hold out_valid=1, with out_data = f(bank[rd_addr]) per lane; out_data is stable while out_ready=0.
REQ-022 rd_addr SHALL advance on each cycle where out_valid & out_ready; no address is skipped or repeated.
REQ-023 The handshake at rd_addr=depth-1 SHALL return the FSM to IDLE and assert done for exactly the following cycle.
REQ-024 start SHALL be ignored in ACCUM and DRAIN.
REQ-025 in_valid outside ACCUM SHALL have no effect.
REQ-026 Latency SHALL be: first out_valid one cycle after the final accepted input beat, with one row per cycle when out_ready=1.

Reset
REQ-027 On reset, state SHALL be IDLE; in_ready, out_valid, busy and done SHALL be 0; out_data SHALL be 0; all counters SHALL be 0.
REQ-028 Bank contents need not be cleared on reset, because pass 0 overwrites them (REQ-017).
REQ-029 Reset mid-ACCUM or mid-DRAIN SHALL abort the job with no done pulse; the next job SHALL show no stale data.

Configuration
REQ-030 With macro PSUM_ACCUM_RELU_EN defined, f(x) SHALL be max(x,0) per lane at drain; bank contents stay signed and unclipped.
REQ-031 Without PSUM_ACCUM_RELU_EN, f(x) SHALL be x, the raw signed value.

Verification
REQ-032 Single pass (num_pass=1): lane k of beat a = a-8 -> drained lane = max(a-8,0) with the macro, raw a-8 without; 16 rows in address order.
REQ-033 Multi-pass and timing (num_pass=3): every beat lane k = k+1 -> every row lane k = 3*(k+1); out_valid is first high 1 cycle after the 48th beat; done pulses 1 cycle after the 16th drain handshake.
REQ-034 Saturation (num_pass=2): lane0 = 20000 twice -> 32767; lane1 = -20000 twice -> -32768 without the macro, 0 with it.
REQ-035 Backpressure: out_ready=0 for 5 cycles at rd_addr 3 -> out_data and out_valid held; rows 3..15 then emitted once each.
REQ-036 Robustness: start pulsed during ACCUM -> ignored; reset after 7 beats, then num_pass=0 job with lane = 5 -> all rows lane = 5 (no stale sums), done asserted once.
